tc2sm_serial: RTL and testbench

//  Bit-serial two's-complement to sign-magnitude converter for the calculator result path.

---
 rtl/tc2sm_serial.sv | 105 ++++++++++
 tb/tb_tc2sm_serial.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tc2sm_serial.sv
// rtl/tc2sm_serial.sv - bit-serial two's-complement to sign-magnitude converter
// Optional most-negative flag output err is built only with TC2SM_MINNEG_ERR_EN defined.
module tc2sm_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef TC2SM_MINNEG_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic             sign_q;
  logic             seen_q;
  logic [WIDTH-2:0] sr_q;
  logic [WIDTH-2:0] res_q;
  logic [CW-1:0]    cnt_q;

  logic             o_bit;
  logic             seen_d;
  logic [WIDTH-1:0] cat;
  logic [WIDTH-2:0] res_d;
  logic             last;

  // Negative words invert every bit after the first 1; positive words pass through.
  always_comb begin
    o_bit  = sr_q[0] ^ (sign_q & seen_q);
    seen_d = seen_q | (sign_q & sr_q[0]);
    cat    = {o_bit, res_q};
    res_d  = cat[WIDTH-1:1];
    last   = (cnt_q == CW'(WIDTH - 2));
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      sign_q    <= 1'b0;
      seen_q    <= 1'b0;
      sr_q      <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
`ifdef TC2SM_MINNEG_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q   <= in_data[WIDTH-1];
            sr_q     <= in_data[WIDTH-2:0];
            seen_q   <= 1'b0;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q   <= sr_q >> 1;
          res_q  <= res_d;
          seen_q <= seen_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last) begin
            out_data  <= {sign_q, res_d};
            out_valid <= 1'b1;
`ifdef TC2SM_MINNEG_ERR_EN
            // No 1 anywhere in a negative magnitude means the input was {1,0..0}.
            err       <= sign_q & ~seen_d;
`endif
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef TC2SM_MINNEG_ERR_EN
            err       <= 1'b0;
`endif
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tc2sm_serial.sv
// tb/tb_tc2sm_serial.sv - self-checking bench for tc2sm_serial at WIDTH=4
module tb_tc2sm_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;
`ifdef TC2SM_MINNEG_ERR_EN
  logic       err;
`endif

  int nchecks = 0;
  int nerrs   = 0;

  always #5 clk = ~clk;

  tc2sm_serial #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
`ifdef TC2SM_MINNEG_ERR_EN
    ,
    .err      (err)
`endif
  );

  typedef struct {
    logic [3:0] din;
    logic [3:0] dout;
    logic       e;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input logic [3:0] din, input logic [3:0] dout, input logic e);
    int lat;
    in_valid = 1'b1;
    in_data  = din;
    tick();
    check("accept_busy", {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check($sformatf("latency_%b", din), lat, 32'd3);
    check($sformatf("data_%b", din), {28'd0, out_data}, {28'd0, dout});
`ifdef TC2SM_MINNEG_ERR_EN
    check($sformatf("err_%b", din), {31'd0, err}, {31'd0, e});
`else
    if (e) begin end
`endif
    out_ready = 1'b1;
    tick();
    check($sformatf("idle_after_%b", din), {29'd0, in_ready, busy, out_valid}, 32'b100);
    out_ready = 1'b0;
  endtask

  initial begin
    int c;
    int seen;
    int t1;
    int t2;
    logic [3:0] d1;
    logic [3:0] d2;
    logic ok;

    vecs[0]  = '{4'b0101, 4'b0101, 1'b0};
    vecs[1]  = '{4'b1101, 4'b1011, 1'b0};
    vecs[2]  = '{4'b1111, 4'b1001, 1'b0};
    vecs[3]  = '{4'b1001, 4'b1111, 1'b0};
    vecs[4]  = '{4'b1000, 4'b1000, 1'b1};
    vecs[5]  = '{4'b0000, 4'b0000, 1'b0};
    vecs[6]  = '{4'b0111, 4'b0111, 1'b0};
    vecs[7]  = '{4'b1110, 4'b1010, 1'b0};
    vecs[8]  = '{4'b0011, 4'b0011, 1'b0};
    vecs[9]  = '{4'b1100, 4'b1100, 1'b0};
    vecs[10] = '{4'b1010, 4'b1110, 1'b0};
    vecs[11] = '{4'b1011, 4'b1101, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = 4'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_state", {26'd0, in_ready, out_valid, out_data, busy}, {26'd0, 1'b1, 1'b0, 4'b0, 1'b0});
`ifdef TC2SM_MINNEG_ERR_EN
    check("reset_err", {31'd0, err}, 32'd0);
`endif

    for (int i = 0; i < 12; i++) convert(vecs[i].din, vecs[i].dout, vecs[i].e);

    // Output stall: DONE must hold everything while out_ready is low.
    in_valid = 1'b1; in_data = 4'b1101;
    tick();
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 10) begin tick(); c++; end
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (!(out_valid && out_data == 4'b1011 && !in_ready && busy)) ok = 1'b0;
    end
    check("stall_stable", {31'd0, ok}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("stall_release", {29'd0, in_ready, busy, out_valid}, 32'b100);
    out_ready = 1'b0;

    // Reset in the second SHIFT cycle aborts the word.
    in_valid = 1'b1; in_data = 4'b0101;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", {29'd0, in_ready, out_valid, busy}, 32'b100);
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_output", seen, 32'd0);
    out_ready = 1'b0;

    // Back-to-back words with in_valid held high and out_ready always 1.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'b0011;
    tick();
    in_data = 4'b1110;
    t1 = -1; t2 = -1; d1 = '0; d2 = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (out_valid) begin
        if (t1 < 0) begin t1 = k; d1 = out_data; end
        else if (t2 < 0) begin t2 = k; d2 = out_data; end
      end
    end
    in_valid = 1'b0;
    check("b2b_first_data", {28'd0, d1}, 32'b0011);
    check("b2b_second_data", {28'd0, d2}, 32'b1010);
    check("b2b_first_time", t1, 32'd3);
    check("b2b_spacing", t2 - t1, 32'd5);
    c = 0;
    while (busy && c < 20) begin tick(); c++; end
    check("b2b_drain", {31'd0, busy}, 32'd0);
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
